axicb_scfifo_fwft: RTL

// Parametrised single-clock FIFO with integrated regfile storage and a first-word-fall-through

---
 rtl/axicb_scfifo_fwft.sv | 137 +++++++++++++
 1 files changed

// File: rtl/axicb_scfifo_fwft.sv
// Single-clock FIFO with internal register-file storage and a first-word-fall-through
// valid/ready output. An optional prefetch register adds one entry of capacity after the RAM.
module axicb_scfifo_fwft #(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int FFD_EN        = 0,
    parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 1,
    parameter int AEMPTY_THRESH = 1,
    parameter int RAM_RST_EN    = 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  srst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  afull,
    output logic                  aempty
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    localparam logic [ADDR_WIDTH:0] ONE        = CW'(1);
    localparam logic [ADDR_WIDTH:0] AFULL_LVL  = CW'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = CW'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  ram_empty;
    logic                  push;
    logic                  pop;
    logic                  ram_rd;
    logic [DATA_WIDTH-1:0] ram_head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign ram_empty = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                       (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign in_ready  = !full;
    assign push      = in_valid && !full;
    assign pop       = out_valid && out_ready;
    assign ram_head  = mem[rd_ptr[ADDR_WIDTH-1:0]];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + ONE;
            if (ram_rd) rd_ptr <= rd_ptr + ONE;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count_q <= '0;
        end else if (srst) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + ONE;
                2'b01:   count_q <= count_q - ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count  = count_q;
    assign empty  = (count_q == '0);
    assign afull  = (count_q >= AFULL_LVL);
    assign aempty = (count_q <= AEMPTY_LVL);

    generate
        if (RAM_RST_EN != 0) begin : g_ram_rst
            // NOTE: clearing a memory on reset costs a reset net per bit; only done when asked for.
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
                end else if (srst) begin
                    for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
                end else if (push) begin
                    mem[wr_ptr[ADDR_WIDTH-1:0]] <= in_data;
                end
            end
        end else begin : g_ram_nrst
            always_ff @(posedge aclk) begin
                if (push && !srst) mem[wr_ptr[ADDR_WIDTH-1:0]] <= in_data;
            end
        end
    endgenerate

    generate
        if (FFD_EN != 0) begin : g_ffd
            logic                  ov_q;
            logic [DATA_WIDTH-1:0] od_q;

            // Prefetch whenever the slot is free or is being drained this cycle.
            assign ram_rd = !ram_empty && (!ov_q || out_ready);

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    ov_q <= 1'b0;
                    od_q <= '0;
                end else if (srst) begin
                    ov_q <= 1'b0;
                    od_q <= '0;
                end else if (ram_rd) begin
                    ov_q <= 1'b1;
                    od_q <= ram_head;
                end else if (out_ready) begin
                    ov_q <= 1'b0;
                end
            end

            assign out_valid = ov_q;
            assign out_data  = od_q;
        end else begin : g_comb
            assign ram_rd    = !ram_empty && out_ready;
            assign out_valid = !ram_empty;
            assign out_data  = ram_empty ? '0 : ram_head;
        end
    endgenerate

endmodule
